pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage that carries one packed stage payload (fetch, decode, execute or memory bundle) between two pipeline stages of the RISC-V core using a valid/ready handshake. It buffers up to DEPTH payloads in order, so a stall in the downstream stage does not combinationally reach the upstream stage. It accepts a flush that squashes every buffered payload. An optional pass-through mode gives zero latency when the buffer is empty.

---
 rtl/pipe_stage_buf.sv | 93 +++++++++
 tb/tb_pipe_stage_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline buffer with flush
// and optional zero-latency pass-through when empty.
module pipe_stage_buf #(
    parameter int DATA_W   = 96,
    parameter int DEPTH    = 2,
    parameter int PASSTHRU = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_thru;
    logic w_wr;
    logic w_rd;

    // Occupancy flags come from the count register alone.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
    end

    // Output selection: head entry, or live input when bypassing.
    always_comb begin
        w_bypass  = (PASSTHRU != 0) && w_empty;
        in_ready  = ~w_full;
        out_valid = w_bypass ? (in_valid & ~flush) : ~w_empty;
        out_data  = w_bypass ? in_data : r_mem[r_rp];
        count     = r_count;
    end

    // A consumed bypass payload never touches storage.
    always_comb begin
        w_push = in_valid & in_ready;
        w_pop  = out_valid & out_ready;
        w_thru = w_bypass & w_push & out_ready;
        w_wr   = w_push & ~w_thru;
        w_rd   = w_pop & ~w_empty;
    end

    // Pointer and count update; flush wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + PTR_W'(1);
            if (w_rd)
                r_rp <= r_rp + PTR_W'(1);
            if (w_wr && !w_rd)
                r_count <= r_count + CNT_W'(1);
            else if (w_rd && !w_wr)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage; flush leaves stored bits untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr && !flush) begin
            r_mem[r_wp] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf
// for DEPTH=2, DEPTH=4 and pass-through configurations.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic        d2_in_valid = 0, d2_in_ready, d2_out_valid;
    logic        d2_out_ready = 0, d2_flush = 0;
    logic [95:0] d2_in_data = '0, d2_out_data;
    logic [1:0]  d2_count;

    logic        d4_in_valid = 0, d4_in_ready, d4_out_valid;
    logic        d4_out_ready = 0, d4_flush = 0;
    logic [95:0] d4_in_data = '0, d4_out_data;
    logic [2:0]  d4_count;

    logic        pt_in_valid = 0, pt_in_ready, pt_out_valid;
    logic        pt_out_ready = 0, pt_flush = 0;
    logic [95:0] pt_in_data = '0, pt_out_data;
    logic [1:0]  pt_count;

    pipe_stage_buf #(.DATA_W(96), .DEPTH(2), .PASSTHRU(0)) u_d2 (
        .clk(clk), .reset(reset),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_data(d2_in_data), .out_valid(d2_out_valid),
        .out_ready(d2_out_ready), .out_data(d2_out_data),
        .flush(d2_flush), .count(d2_count)
    );

    pipe_stage_buf #(.DATA_W(96), .DEPTH(4), .PASSTHRU(0)) u_d4 (
        .clk(clk), .reset(reset),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .in_data(d4_in_data), .out_valid(d4_out_valid),
        .out_ready(d4_out_ready), .out_data(d4_out_data),
        .flush(d4_flush), .count(d4_count)
    );

    pipe_stage_buf #(.DATA_W(96), .DEPTH(2), .PASSTHRU(1)) u_pt (
        .clk(clk), .reset(reset),
        .in_valid(pt_in_valid), .in_ready(pt_in_ready),
        .in_data(pt_in_data), .out_valid(pt_out_valid),
        .out_ready(pt_out_ready), .out_data(pt_out_data),
        .flush(pt_flush), .count(pt_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [95:0] vals [4];
    logic [95:0] q [$];
    logic [1:0]  pat [9];
    logic        m_push, m_pop;

    initial begin
        vals[0] = 96'h11; vals[1] = 96'h22;
        vals[2] = 96'h33; vals[3] = 96'h44;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_d2_valid", 96'(d2_out_valid), 96'd0);
        chk("rst_d2_ready", 96'(d2_in_ready), 96'd1);
        chk("rst_d2_count", 96'(d2_count), 96'd0);
        chk("rst_d2_data", d2_out_data, 96'd0);
        chk("rst_d4_count", 96'(d4_count), 96'd0);
        chk("rst_d4_ready", 96'(d4_in_ready), 96'd1);
        chk("rst_pt_valid", 96'(pt_out_valid), 96'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset mid-operation on DEPTH=2
        d2_in_valid = 1; d2_in_data = 96'hAB01;
        tick();
        d2_in_data = 96'hAB02;
        tick();
        d2_in_valid = 0;
        #1;
        chk("mid_pre_count", 96'(d2_count), 96'd2);
        chk("mid_pre_data", d2_out_data, 96'hAB01);
        reset = 1'b1;
        #1;
        chk("mid_valid", 96'(d2_out_valid), 96'd0);
        chk("mid_count", 96'(d2_count), 96'd0);
        chk("mid_ready", 96'(d2_in_ready), 96'd1);
        chk("mid_data", d2_out_data, 96'd0);
        reset = 1'b0;
        d2_in_valid = 1; d2_in_data = 96'h77;
        tick();
        d2_in_valid = 0;
        #1;
        chk("post_rst_data", d2_out_data, 96'h77);
        chk("post_rst_count", 96'(d2_count), 96'd1);
        d2_out_ready = 1;
        tick();
        d2_out_ready = 0;
        #1;
        chk("post_rst_drain", 96'(d2_count), 96'd0);

        // Fill and stall on DEPTH=4
        for (int k = 0; k < 4; k++) begin
            d4_in_valid = 1; d4_in_data = vals[k];
            tick();
        end
        d4_in_data = 96'h55;
        #1;
        chk("fill_count", 96'(d4_count), 96'd4);
        chk("fill_ready", 96'(d4_in_ready), 96'd0);
        chk("fill_head", d4_out_data, 96'h11);
        tick();
        d4_in_valid = 0;
        #1;
        chk("fifth_ignored", 96'(d4_count), 96'd4);
        d4_out_ready = 1;
        #1;
        chk("full_ready_hold", 96'(d4_in_ready), 96'd0);
        for (int k = 0; k < 4; k++) begin
            chk("pop_valid", 96'(d4_out_valid), 96'd1);
            chk("pop_data", d4_out_data, vals[k]);
            tick();
            if (k == 0) begin
                chk("ready_after_pop", 96'(d4_in_ready), 96'd1);
                chk("count_after_pop", 96'(d4_count), 96'd3);
            end
        end
        chk("drain_count", 96'(d4_count), 96'd0);
        chk("drain_valid", 96'(d4_out_valid), 96'd0);
        tick();
        chk("empty_pop_count", 96'(d4_count), 96'd0);
        d4_out_ready = 0;

        // Streaming on DEPTH=2
        for (int i = 0; i < 100; i++) begin
            d2_in_valid = 1; d2_out_ready = 1;
            d2_in_data = 96'(i);
            #1;
            if (i == 0) begin
                chk("stream_first", 96'(d2_out_valid), 96'd0);
            end else begin
                chk("stream_data", d2_out_data, 96'(i - 1));
                chk("stream_vc",
                    96'({d2_out_valid, d2_count <= 2'd1}),
                    96'd3);
            end
            tick();
        end
        d2_in_valid = 0;
        #1;
        chk("stream_last", d2_out_data, 96'd99);
        tick();
        chk("stream_end_cnt", 96'(d2_count), 96'd0);
        chk("stream_end_vld", 96'(d2_out_valid), 96'd0);

        // Flush with simultaneous push and pop
        d2_out_ready = 0;
        d2_in_valid = 1; d2_in_data = 96'hA;
        tick();
        d2_in_data = 96'hB;
        tick();
        d2_flush = 1; d2_in_data = 96'hC; d2_out_ready = 1;
        #1;
        chk("flush_pre_cnt", 96'(d2_count), 96'd2);
        chk("flush_pre_vld", 96'(d2_out_valid), 96'd1);
        chk("flush_pre_data", d2_out_data, 96'hA);
        tick();
        d2_flush = 0; d2_in_valid = 0;
        #1;
        chk("flush_count", 96'(d2_count), 96'd0);
        chk("flush_valid", 96'(d2_out_valid), 96'd0);
        chk("flush_ready", 96'(d2_in_ready), 96'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_quiet", 96'(d2_out_valid), 96'd0);
        end
        d2_in_valid = 1; d2_in_data = 96'hD;
        tick();
        d2_in_valid = 0;
        #1;
        chk("flush_next", d2_out_data, 96'hD);
        chk("flush_next_cnt", 96'(d2_count), 96'd1);
        tick();
        chk("flush_drain", 96'(d2_count), 96'd0);

        // Pointer wrap against a reference queue
        pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b11;
        pat[3] = 2'b01; pat[4] = 2'b10; pat[5] = 2'b10;
        pat[6] = 2'b11; pat[7] = 2'b01; pat[8] = 2'b01;
        q = {};
        for (int k = 0; k < 9; k++) begin
            d2_in_valid  = pat[k][1];
            d2_out_ready = pat[k][0];
            d2_in_data   = 96'h100 + 96'(k);
            #1;
            chk("wrap_count", 96'(d2_count), 96'(q.size()));
            chk("wrap_valid", 96'(d2_out_valid),
                96'(q.size() != 0));
            chk("wrap_ready", 96'(d2_in_ready),
                96'(q.size() != 2));
            if (q.size() != 0)
                chk("wrap_data", d2_out_data, q[0]);
            m_push = pat[k][1] && (q.size() != 2);
            m_pop  = pat[k][0] && (q.size() != 0);
            if (m_pop)
                void'(q.pop_front());
            if (m_push)
                q.push_back(d2_in_data);
            tick();
        end
        d2_in_valid = 0; d2_out_ready = 0;
        #1;
        chk("wrap_end", 96'(d2_count), 96'(q.size()));

        // Pass-through, consumed directly
        pt_in_valid = 1; pt_in_data = 96'h5A; pt_out_ready = 1;
        #1;
        chk("pt_valid", 96'(pt_out_valid), 96'd1);
        chk("pt_data", pt_out_data, 96'h5A);
        tick();
        chk("pt_count0", 96'(pt_count), 96'd0);

        // Pass-through, stalled downstream
        pt_out_ready = 0;
        #1;
        chk("pt_stall_vld", 96'(pt_out_valid), 96'd1);
        tick();
        pt_in_valid = 0;
        #1;
        chk("pt_stall_cnt", 96'(pt_count), 96'd1);
        chk("pt_stall_data", pt_out_data, 96'h5A);
        chk("pt_stall_vld2", 96'(pt_out_valid), 96'd1);
        pt_out_ready = 1;
        tick();
        chk("pt_pop_cnt", 96'(pt_count), 96'd0);
        chk("pt_pop_vld", 96'(pt_out_valid), 96'd0);

        // Pass-through blocked by flush
        pt_in_valid = 1; pt_in_data = 96'h66; pt_flush = 1;
        #1;
        chk("pt_flush_vld", 96'(pt_out_valid), 96'd0);
        tick();
        pt_flush = 0; pt_in_valid = 0;
        #1;
        chk("pt_flush_cnt", 96'(pt_count), 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
